// File: rtl/led_pattern_ctrl.sv
// Four-mode LED pattern stepper driven by an external tick, with a debounced mode button.
// Optional long-press freeze is built only when KEY_LONG_PRESS_EN is defined.
module led_pattern_ctrl #(
  parameter int DEB_CNT  = 1_000_000,
  parameter int LONG_CNT = 50_000_000
) (
  input  logic       Clk50M,
  input  logic       Rst_n,
  input  logic       tick,
  input  logic       key_n,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic       frozen
);

  // state  | meaning
  // FLOW   | one-hot rotates left each tick
  // BLINK  | all four LEDs invert each tick
  // BOUNCE | one-hot walks up to 1000, then back down to 0001
  // BIN    | LEDs count up in binary each tick
  typedef enum logic [1:0] {FLOW = 2'd0, BLINK = 2'd1, BOUNCE = 2'd2, BIN = 2'd3} mode_e;

  localparam int DEB_W = $clog2(DEB_CNT + 1);

  if (DEB_CNT < 1 || LONG_CNT < 1) begin : g_param_chk
    $error("led_pattern_ctrl: DEB_CNT and LONG_CNT must be at least 1");
  end

  logic             key_s1, key_s;
  logic             key_db, key_db_d;
  logic [DEB_W-1:0] deb_cnt;
  logic             press;
  logic             frozen_q;

  mode_e      mode_q, mode_nxt;
  logic [3:0] led_q, led_nxt;
  logic       dir_dn, dir_dn_nxt;

  // Down-counter is reloaded whenever key_s agrees with key_db, so any bounce restarts the window.
  always_ff @(posedge Clk50M or negedge Rst_n) begin
    if (!Rst_n) begin
      key_s1   <= 1'b1;
      key_s    <= 1'b1;
      key_db   <= 1'b1;
      key_db_d <= 1'b1;
      deb_cnt  <= '0;
    end else begin
      key_s1   <= key_n;
      key_s    <= key_s1;
      key_db_d <= key_db;
      if (key_s == key_db) begin
        deb_cnt <= DEB_W'(DEB_CNT - 1);
      end else if (deb_cnt == '0) begin
        key_db  <= key_s;
        deb_cnt <= DEB_W'(DEB_CNT - 1);
      end else begin
        deb_cnt <= deb_cnt - DEB_W'(1);
      end
    end
  end

  assign press = key_db_d & ~key_db;

`ifdef KEY_LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_CNT + 1);
  logic [HOLD_W-1:0] hold_cnt;

  // Saturates at LONG_CNT so one hold toggles frozen exactly once.
  always_ff @(posedge Clk50M or negedge Rst_n) begin
    if (!Rst_n) begin
      hold_cnt <= '0;
      frozen_q <= 1'b0;
    end else if (key_db) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_W'(LONG_CNT)) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
      if (hold_cnt == HOLD_W'(LONG_CNT - 1)) frozen_q <= ~frozen_q;
    end
  end
`else
  assign frozen_q = 1'b0;
`endif

  function automatic logic [3:0] init_pat(input mode_e m);
    case (m)
      BLINK:   init_pat = 4'b1111;
      BIN:     init_pat = 4'b0000;
      default: init_pat = 4'b0001;
    endcase
  endfunction

  always_ff @(posedge Clk50M or negedge Rst_n) begin
    if (!Rst_n) begin
      mode_q <= FLOW;
      led_q  <= 4'b0001;
      dir_dn <= 1'b0;
    end else begin
      mode_q <= mode_nxt;
      led_q  <= led_nxt;
      dir_dn <= dir_dn_nxt;
    end
  end

  // A press outranks a same-cycle tick; that tick is simply dropped.
  always_comb begin
    mode_nxt   = mode_q;
    led_nxt    = led_q;
    dir_dn_nxt = dir_dn;
    if (press) begin
      mode_nxt   = mode_e'(mode_q + 2'd1);
      led_nxt    = init_pat(mode_nxt);
      dir_dn_nxt = 1'b0;
    end else if (tick && !frozen_q) begin
      case (mode_q)
        FLOW:  led_nxt = {led_q[2:0], led_q[3]};
        BLINK: led_nxt = ~led_q;
        BOUNCE: begin
          if (!dir_dn) begin
            led_nxt = {led_q[2:0], 1'b0};
            if (led_nxt == 4'b1000) dir_dn_nxt = 1'b1;
          end else begin
            led_nxt = {1'b0, led_q[3:1]};
            if (led_nxt == 4'b0001) dir_dn_nxt = 1'b0;
          end
        end
        BIN:     led_nxt = led_q + 4'd1;
        default: led_nxt = led_q;
      endcase
    end
  end

  assign led    = led_q;
  assign mode   = mode_q;
  assign frozen = frozen_q;

endmodule

// File: doc/led_pattern_ctrl.md
LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 The block SHALL have parameter DEB_CNT, default 1_000_000, giving the key debounce stable time in clocks (20 ms at 50 MHz).
REQ-002 The block SHALL have parameter LONG_CNT, default 50_000_000, giving the long-press threshold in clocks (1 s); it is used only when KEY_LONG_PRESS_EN is defined.
REQ-003 The block SHALL have port Clk50M, input, 1 bit: 50 MHz system clock; the block uses one clock only.
REQ-004 The block SHALL have port Rst_n, input, 1 bit: global reset, asynchronous, active-low.
REQ-005 The block SHALL have port tick, input, 1 bit: one-cycle step pulse from the upstream 0.5 s prescaler counter.
REQ-006 The block SHALL have port key_n, input, 1 bit: raw mode button, asynchronous, active-low.
REQ-007 The block SHALL have port led, output reg, 4 bits: LED pattern, 1 = lit.
REQ-008 The block SHALL have port mode, output reg, 2 bits: current pattern mode.
REQ-009 The block SHALL have port frozen, output reg, 1 bit: high while stepping is paused.

Function
REQ-010 key_n SHALL pass through a 2-FF synchronizer, producing key_s, before any other use.
REQ-011 Debounce: key_db SHALL take the value of key_s once key_s has differed from key_db for DEB_CNT consecutive clocks; any return to equality SHALL clear the stability counter.
REQ-012 A press SHALL be the key_db 1->0 transition; it SHALL produce exactly one internal one-cycle pulse, and mode SHALL update on the next clock edge.
REQ-013 On each press, mode SHALL advance 0->1->2->3->0, and led SHALL load the new mode's initial pattern at the same edge.
REQ-014 Mode 0 (FLOW), initial 0001: on each tick, rotate left, with 1000 -> 0001.
REQ-015 Mode 1 (BLINK), initial 1111: on each tick, invert all bits (1111 <-> 0000).
REQ-016 Mode 2 (BOUNCE), initial 0001 with direction up: on each tick, shift one-hot toward the current direction; direction SHALL flip on reaching 1000 or 0001, giving the sequence 0001,0010,0100,1000,0100,0010,0001,...
REQ-017 Mode 3 (BIN), initial 0000: on each tick, led += 1 modulo 16, with 1111 -> 0000.
REQ-018 With no tick and no press, led and mode SHALL hold.
REQ-019 If a press pulse and a tick occur in the same cycle, the mode change SHALL win and that tick SHALL be discarded.
REQ-020 While frozen=1, ticks SHALL be ignored, but presses SHALL still change mode and load its initial pattern.
REQ-021 Back-to-back ticks on consecutive cycles SHALL each produce one step.

Reset
REQ-022 While Rst_n=0, the block SHALL asynchronously force: led=4'b0001, mode=2'd0, frozen=0, bounce direction up, key_s and synchronizer stages = 1, key_db=1, all counters = 0.
REQ-023 A reset asserted mid-debounce or mid-pattern SHALL discard all progress; after release, operation SHALL restart from FLOW 0001 and no press SHALL be generated by the release itself.

Configuration
REQ-024 Macro KEY_LONG_PRESS_EN defined: while key_db=0, a hold counter SHALL count clocks; when it reaches LONG_CNT, frozen SHALL toggle exactly once per hold, and the counter SHALL saturate until key_db returns to 1, then clear.
REQ-025 Macro KEY_LONG_PRESS_EN defined: the press at the start of a long hold SHALL still advance mode.
REQ-026 Macro KEY_LONG_PRESS_EN undefined: no hold counter SHALL be built, frozen SHALL be constant 0, and LONG_CNT SHALL be unused.

Verification (DEB_CNT=4, LONG_CNT=20)
REQ-027 Reset release, then 5 ticks -> led steps 0001,0010,0100,1000,0001,0010; mode=0.
REQ-028 key_n glitch low for 3 clocks -> no mode change; key_n held low for 10 clocks -> mode=1 and led=1111 within 2+4+2 clocks of the fall, with exactly one advance.
REQ-029 In mode 2, apply 7 ticks -> led 0010,0100,1000,0100,0010,0001,0010.
REQ-030 In mode 3 with led=1111, tick -> led=0000; press pulse coincident with tick -> mode=0, led=0001, tick discarded.
REQ-031 With KEY_LONG_PRESS_EN, hold key low for 40 clocks -> mode advances once and frozen=1; ticks leave led unchanged; second long hold -> frozen=0. Without the macro -> frozen stays 0.
REQ-032 Assert Rst_n=0 mid-debounce in mode 2 -> led=0001, mode=0, frozen=0 immediately (asynchronously); no spurious press after release.
